wb_initiator: RTL and testbench

Wishbone classic initiator that drives the slave port of `wb_system` and fills the unconnected debug/host bus on the iCEBreaker top. Accepts single read/write commands over a valid/ready interface, runs exactly one Wishbone cycle per command, and returns the read data and a status on a valid/ready response interface. A host-side bridge such as the UART "spoke" sits upstream; it never handles bus timing itself.

---
 rtl/wb_initiator_pkg.sv | 24 ++
 rtl/wb_initiator_timeout.sv | 45 ++++
 rtl/wb_initiator.sv | 136 +++++++++++++
 tb/tb_wb_initiator.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_initiator_pkg.sv
// Shared definitions for the Wishbone classic initiator.
//
// Holds the FSM state encodings, the default bus widths (also used by
// wb_system) and a helper that sizes the timeout counter.
//
// Optional feature macro used by this slice: WB_INITIATOR_TIMEOUT_EN.
package wb_initiator_pkg;

  localparam int WB_ADDR_WIDTH = 32;
  localparam int WB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    WB_ST_IDLE = 2'd0,
    WB_ST_BUS  = 2'd1,
    WB_ST_RESP = 2'd2
  } wb_state_e;

  // Counter wide enough to hold the limit itself, so it never wraps
  // before the terminal count is reached.
  function automatic int wb_count_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/wb_initiator_timeout.sv
// wb_timeout: strobe-high cycle counter for the Wishbone initiator.
//
// Only compiled when WB_INITIATOR_TIMEOUT_EN is defined; without the macro
// the initiator waits for ack indefinitely and this module does not exist.
//
// Ports:
//   clock    in  rising-edge clock
//   reset_n  in  asynchronous active-low reset
//   clear    in  restart the count (new bus cycle starting)
//   run      in  one more strobe cycle elapsed without ack
//   expired  out this edge brings the count to LIMIT (combinational)
`ifdef WB_INITIATOR_TIMEOUT_EN
module wb_timeout
  import wb_initiator_pkg::*;
#(
  parameter int LIMIT = 15
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = wb_count_width(LIMIT);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (run) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  // Flagged one edge early so the FSM leaves BUS on exactly the edge that
  // completes LIMIT strobe cycles.
  assign expired = run && (count_reg == LAST);

endmodule
`endif

// File: rtl/wb_initiator.sv
// wb_initiator: Wishbone classic initiator, one bus cycle per command.
//
// Commands arrive on a valid/ready interface, each runs a single Wishbone
// classic cycle, and the read data plus an abort flag are returned on a
// valid/ready response interface.
//
// Optional feature: WB_INITIATOR_TIMEOUT_EN builds the timeout counter and
// abort path. Without it the bus waits for ack forever and rsp_err is 0.
//
// Ports:
//   clock, reset_n                  clock / async active-low reset
//   cmd_valid, cmd_ready            command handshake
//   cmd_we, cmd_addr, cmd_data      command payload
//   rsp_valid, rsp_ready            response handshake
//   rsp_data, rsp_err               response payload
//   wb_addr_o, wb_data_o, wb_we_o   Wishbone request
//   wb_cyc_o, wb_strobe_o           Wishbone cycle / strobe
//   wb_data_i, wb_ack_i             Wishbone reply
module wb_initiator
  import wb_initiator_pkg::*;
#(
  parameter int ADDR_WIDTH     = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = WB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  output logic                  wb_we_o,
  output logic                  wb_cyc_o,
  output logic                  wb_strobe_o,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  input  logic                  wb_ack_i
);

  wb_state_e state_reg;
  logic      accept;
  logic      expired;

  // Decoded from the state register only: no input reaches cmd_ready.
  assign cmd_ready = (state_reg == WB_ST_IDLE);
  assign accept    = cmd_ready && cmd_valid;

`ifdef WB_INITIATOR_TIMEOUT_EN
  logic err_reg;
  logic bus_wait;

  assign bus_wait = (state_reg == WB_ST_BUS) && !wb_ack_i;
  assign rsp_err  = err_reg;

  wb_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (accept),
    .run     (bus_wait),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= WB_ST_IDLE;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      wb_addr_o   <= '0;
      wb_data_o   <= '0;
      wb_we_o     <= 1'b0;
      wb_cyc_o    <= 1'b0;
      wb_strobe_o <= 1'b0;
`ifdef WB_INITIATOR_TIMEOUT_EN
      err_reg     <= 1'b0;
`endif
    end else begin
      case (state_reg)
        WB_ST_IDLE: begin
          if (accept) begin
            wb_we_o     <= cmd_we;
            wb_addr_o   <= cmd_addr;
            wb_data_o   <= cmd_data;
            wb_cyc_o    <= 1'b1;
            wb_strobe_o <= 1'b1;
            state_reg   <= WB_ST_BUS;
          end
        end
        WB_ST_BUS: begin
          // Ack is checked first so an ack on the expiry edge still wins.
          if (wb_ack_i) begin
            wb_cyc_o    <= 1'b0;
            wb_strobe_o <= 1'b0;
            rsp_data    <= wb_we_o ? '0 : wb_data_i;
            rsp_valid   <= 1'b1;
`ifdef WB_INITIATOR_TIMEOUT_EN
            err_reg     <= 1'b0;
`endif
            state_reg   <= WB_ST_RESP;
          end else if (expired) begin
            wb_cyc_o    <= 1'b0;
            wb_strobe_o <= 1'b0;
            rsp_data    <= '0;
            rsp_valid   <= 1'b1;
`ifdef WB_INITIATOR_TIMEOUT_EN
            err_reg     <= 1'b1;
`endif
            state_reg   <= WB_ST_RESP;
          end
        end
        WB_ST_RESP: begin
          // Return to IDLE only; the next command is taken a cycle later.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_reg <= WB_ST_IDLE;
          end
        end
        default: begin
          state_reg <= WB_ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_initiator.sv
`timescale 1ns/1ps
module tb_wb_initiator;

  localparam int TO = 15;
`ifdef WB_INITIATOR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_data_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_strobe_o;
  logic [31:0] wb_data_i = '0;
  logic        wb_ack_i = 1'b0;

  wb_initiator #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_we      (cmd_we),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .wb_addr_o   (wb_addr_o),
    .wb_data_o   (wb_data_o),
    .wb_we_o     (wb_we_o),
    .wb_cyc_o    (wb_cyc_o),
    .wb_strobe_o (wb_strobe_o),
    .wb_data_i   (wb_data_i),
    .wb_ack_i    (wb_ack_i)
  );

  always #5 clock = ~clock;

  int edge_n = 0;
  always @(posedge clock) edge_n <= edge_n + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @edge %0d: got %b, want %b", name, edge_n, act, exp);
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @edge %0d: got %h, want %h", name, edge_n, act, exp);
  endtask

  // Transaction timeline model. A command handshaken at edge H with ack
  // planned on strobe cycle k (0-based) and d cycles of response stall:
  //   strobe cycles S = k+1, capped at TO when the timeout is built;
  //   after edges H..H+S-1 the bus is active;
  //   after edges H+S..H+S+d the response is presented;
  //   afterwards the initiator is idle again.
  bit          m_active = 1'b0;
  int          m_hs = 0, m_s = 0, m_d = 0, m_k = 0;
  bit          m_we = 1'b0, m_err = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0, m_rsp = '0;

  function automatic int strobe_cycles(input int k);
    if (TO_EN && (k + 1 > TO)) return TO;
    return k + 1;
  endfunction

  function automatic bit model_idle();
    return !m_active || (edge_n - m_hs > m_s + m_d);
  endfunction

  // Observations taken from the DUT for the literal expectations.
  int          obs_stb = 0;
  int          obs_lat = -1;
  logic [31:0] obs_data = '0;
  logic        obs_err = 1'b0;

  int cmp_t;
  bit exp_bus, exp_rsp;

  always @(negedge clock) begin
    if (!reset_n) begin
      check_bit("rst_cyc", wb_cyc_o, 1'b0);
      check_bit("rst_stb", wb_strobe_o, 1'b0);
      check_bit("rst_we", wb_we_o, 1'b0);
      check_bit("rst_rsp_valid", rsp_valid, 1'b0);
      check_bit("rst_rsp_err", rsp_err, 1'b0);
      check_word("rst_rsp_data", rsp_data, 32'h0);
      check_word("rst_addr", wb_addr_o, 32'h0);
      check_word("rst_wdata", wb_data_o, 32'h0);
    end else begin
      cmp_t   = edge_n - m_hs;
      exp_bus = m_active && (cmp_t >= 0) && (cmp_t < m_s);
      exp_rsp = m_active && (cmp_t >= m_s) && (cmp_t <= m_s + m_d);
      check_bit("cmd_ready", cmd_ready, !(exp_bus || exp_rsp));
      check_bit("cyc", wb_cyc_o, exp_bus);
      check_bit("stb", wb_strobe_o, exp_bus);
      check_bit("rsp_valid", rsp_valid, exp_rsp);
      if (exp_bus) begin
        check_bit("bus_we", wb_we_o, m_we);
        check_word("bus_addr", wb_addr_o, m_addr);
        check_word("bus_wdata", wb_data_o, m_wdata);
      end
      if (exp_rsp) begin
        check_word("rsp_data", rsp_data, m_rsp);
        check_bit("rsp_err", rsp_err, m_err);
      end
      if (wb_strobe_o) obs_stb++;
      if (rsp_valid) begin
        if (obs_lat < 0) obs_lat = cmp_t;
        obs_data = rsp_data;
        obs_err  = rsp_err;
      end
    end
  end

  // Bus responder and response consumer, driven from the model timeline.
  int  rs_t;
  bit  rs_win;
  initial begin
    forever begin
      @(negedge clock);
      #1;
      rs_t      = edge_n - m_hs;
      rs_win    = m_active && (rs_t >= 0) && (rs_t < m_s);
      wb_data_i = $urandom;
      if (rs_win) begin
        wb_ack_i = (rs_t == m_k);
        if (rs_t == m_k) wb_data_i = m_rdata;
      end else begin
        wb_ack_i = ($urandom_range(0, 3) == 0);  // spurious, must be ignored
      end
      if (m_active && (rs_t >= m_s) && (rs_t < m_s + m_d)) rsp_ready = 1'b0;
      else if (m_active && (rs_t == m_s + m_d)) rsp_ready = 1'b1;
      else rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  // Present a command; it stays valid (queued) until the model is idle.
  task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input int k, input int d);
    int guard;
    guard     = 0;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_data  = wdata;
    while (!model_idle() && guard < 2000) begin
      @(negedge clock);
      #1;
      guard++;
    end
    if (!model_idle()) begin
      n_checks++;
      $display("FAIL accept_bound: command still not accepted after %0d cycles", guard);
    end
    m_hs     = edge_n + 1;
    m_k      = k;
    m_d      = d;
    m_s      = strobe_cycles(k);
    m_err    = TO_EN && (k + 1 > TO);
    m_we     = we;
    m_addr   = addr;
    m_wdata  = wdata;
    m_rdata  = rdata;
    m_rsp    = (we || m_err) ? 32'h0 : rdata;
    m_active = 1'b1;
    obs_stb  = 0;
    obs_lat  = -1;
    @(negedge clock);
    #1;
    cmd_valid = 1'b0;
    cmd_we    = 1'($urandom_range(0, 1));
    cmd_addr  = $urandom;
    cmd_data  = $urandom;
  endtask

  task automatic idle_cycles(input int n);
    cmd_valid = 1'b0;
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic wait_done();
    int guard;
    guard     = 0;
    cmd_valid = 1'b0;
    while (!model_idle() && guard < 2000) begin
      @(negedge clock);
      #1;
      guard++;
    end
    if (!model_idle()) begin
      n_checks++;
      $display("FAIL done_bound: transaction not finished after %0d cycles", guard);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  int k_r, d_r;
  logic [31:0] late_data;

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    #3 reset_n = 1'b1;
    @(negedge clock);
    #1;

    // Write, zero wait states.
    issue(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 32'h5555_AAAA, 0, 0);
    wait_done();
    check_word("wr_stb_cycles", 32'(obs_stb), 32'd1);
    check_word("wr_rsp_latency", 32'(obs_lat), 32'd1);
    check_word("wr_rsp_data", obs_data, 32'h0);
    check_bit("wr_rsp_err", obs_err, 1'b0);

    // Read, three wait states.
    issue(1'b0, 32'h0000_0100, 32'h0BAD_0BAD, 32'h1234_5678, 3, 0);
    wait_done();
    check_word("rd3_stb_cycles", 32'(obs_stb), 32'd4);
    check_word("rd3_rsp_latency", 32'(obs_lat), 32'd4);
    check_word("rd3_rsp_data", obs_data, 32'h1234_5678);
    check_bit("rd3_rsp_err", obs_err, 1'b0);

    // Responder acks very late (never, when the timeout is built).
    late_data = 32'h7777_0120;
    issue(1'b0, 32'h0000_0200, 32'h0, late_data, 120, 1);
    wait_done();
`ifdef WB_INITIATOR_TIMEOUT_EN
    check_word("to_stb_cycles", 32'(obs_stb), 32'd15);
    check_word("to_rsp_data", obs_data, 32'h0);
    check_bit("to_rsp_err", obs_err, 1'b1);
`else
    check_word("late_stb_cycles", 32'(obs_stb), 32'd121);
    check_word("late_rsp_data", obs_data, 32'h7777_0120);
    check_bit("late_rsp_err", obs_err, 1'b0);
`endif

    // Ack on the expiry cycle: the ack wins.
    issue(1'b0, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 14, 0);
    wait_done();
    check_word("exp_stb_cycles", 32'(obs_stb), 32'd15);
    check_word("exp_rsp_data", obs_data, 32'hCAFE_F00D);
    check_bit("exp_rsp_err", obs_err, 1'b0);

    // Response backpressure with a second command queued behind it.
    issue(1'b0, 32'h0000_0400, 32'h0, 32'hA5A5_0001, 1, 5);
    issue(1'b1, 32'h0000_0404, 32'h0102_0304, 32'h0, 0, 0);
    wait_done();
    check_word("q2_stb_cycles", 32'(obs_stb), 32'd1);
    check_word("q2_rsp_data", obs_data, 32'h0);

    // Reset in the middle of a long bus wait.
    issue(1'b0, 32'h0000_0500, 32'h0, 32'hFFFF_0000, 50, 0);
    idle_cycles(3);
    #2 reset_n = 1'b0;
    #1;
    check_bit("async_rst_cyc", wb_cyc_o, 1'b0);
    check_bit("async_rst_stb", wb_strobe_o, 1'b0);
    check_bit("async_rst_rsp_valid", rsp_valid, 1'b0);
    m_active = 1'b0;
    repeat (2) @(negedge clock);
    #3 reset_n = 1'b1;
    @(negedge clock);
    #1;
    check_bit("post_rst_cmd_ready", cmd_ready, 1'b1);
    idle_cycles(10);  // spurious acks arrive; no response may appear

    // Randomized traffic, commands often queued back to back.
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 7))
        0:       k_r = TO - 2 + int'($urandom_range(0, 4));
        1:       k_r = 30;
        default: k_r = int'($urandom_range(0, 4));
      endcase
      d_r = int'($urandom_range(0, 4));
      issue(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, k_r, d_r);
      if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 3)));
    end
    wait_done();
    idle_cycles(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
